mem_responder: RTL and testbench

Memory-side responder for the CPU's memory command interface. It accepts `mem_cmd`/`mem_addr`/`write_data` from the controller and serves them from a 256×16 synchronous RAM plus two memory-mapped I/O locations: switches (read) and LEDs (write). It returns registered `read_data` with fixed one-cycle latency, matching the controller's IF1/IF2 and LDR3/LDR4 timing. It also latches a sticky bus-fault record for illegal accesses.

---
 rtl/mem_responder_pkg.sv | 32 +++
 rtl/mem_responder_if.sv | 26 ++
 rtl/mem_responder_ram_sync_1p.sv | 29 ++
 rtl/mem_responder.sv | 131 +++++++++++++
 tb/tb_mem_responder.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory command interface: command encodings,
// access-FSM state type and the default I/O addresses.
package mem_pkg;

    typedef logic [1:0] mem_cmd_t;

    localparam mem_cmd_t MREAD    = 2'b00;
    localparam mem_cmd_t MNONE    = 2'b01;
    localparam mem_cmd_t MWRITE   = 2'b10;
    localparam mem_cmd_t MILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RD   = 2'b01,
        ST_WR   = 2'b10
    } acc_state_t;

    localparam logic [8:0] SW_ADDR_DEF  = 9'h140;
    localparam logic [8:0] LED_ADDR_DEF = 9'h100;

    // The access state is purely a function of the command sampled this cycle.
    function automatic acc_state_t cmd_to_state(input mem_cmd_t cmd);
        acc_state_t st;
        case (cmd)
            MREAD:   st = ST_RD;
            MWRITE:  st = ST_WR;
            default: st = ST_IDLE;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Command/response bundle between the memory controller (master) and the
// memory responder (slave).
interface mem_responder_if
    import mem_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 9
);
    mem_cmd_t            mem_cmd;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   write_data;
    logic [DATA_W-1:0]   read_data;
    logic                fault;
    logic [ADDR_W-1:0]   fault_addr;
    acc_state_t          acc_state;

    modport master (
        output mem_cmd, mem_addr, write_data,
        input  read_data, fault, fault_addr, acc_state
    );

    modport slave (
        input  mem_cmd, mem_addr, write_data,
        output read_data, fault, fault_addr, acc_state
    );
endinterface

// File: rtl/mem_responder_ram_sync_1p.sv
// Single-port synchronous RAM with a registered read port that only updates
// on a read enable, so the last read word is held between reads.
module ram_sync_1p #(
    parameter int DATA_W = 16,
    parameter int RAM_AW = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [RAM_AW-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem_q [0:(1<<RAM_AW)-1];
    logic [DATA_W-1:0] rdata_q;

    // Array write and read-register load; contents survive reset by design.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem_q[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: RAM + switch/LED I/O decode, one-cycle registered
// read data, switch synchronizer and sticky first-fault capture.
module mem_responder
    import mem_pkg::*;
#(
    parameter int               DATA_W   = 16,
    parameter int               ADDR_W   = 9,
    parameter int               RAM_AW   = 8,
    parameter logic [ADDR_W-1:0] SW_ADDR  = SW_ADDR_DEF,
    parameter logic [ADDR_W-1:0] LED_ADDR = LED_ADDR_DEF
) (
    input  logic            clk,
    input  logic            reset,
    mem_responder_if.slave  bus,
    input  logic [7:0]      sw_in,
    output logic [7:0]      led_out
);
    acc_state_t        state_d, state_q;
    logic              src_ram_d, src_ram_q;
    logic [DATA_W-1:0] io_data_d, io_data_q;
    logic [7:0]        led_d, led_q;
    logic              fault_d, fault_q;
    logic [ADDR_W-1:0] fault_addr_d, fault_addr_q;
    logic [7:0]        sw_meta_d, sw_meta_q;
    logic [7:0]        sw_sync_d, sw_sync_q;
    logic              is_ram_s, is_sw_s, is_led_s;
    logic              illegal_s, ram_we_s, ram_re_s;
    logic [DATA_W-1:0] ram_rdata_s;

    assign is_ram_s = ~bus.mem_addr[ADDR_W-1];
    assign is_sw_s  = (bus.mem_addr == SW_ADDR);
    assign is_led_s = (bus.mem_addr == LED_ADDR);

    // Decode, next-state, I/O register updates and fault capture.
    always_comb begin
        state_d      = cmd_to_state(bus.mem_cmd);
        src_ram_d    = src_ram_q;
        io_data_d    = io_data_q;
        led_d        = led_q;
        fault_d      = fault_q;
        fault_addr_d = fault_addr_q;
        illegal_s    = 1'b0;
        ram_we_s     = 1'b0;
        ram_re_s     = 1'b0;
        sw_meta_d    = sw_in;
        sw_sync_d    = sw_meta_q;

        case (state_d)
            ST_RD: begin
                if (is_ram_s) begin
                    src_ram_d = 1'b1;
                    ram_re_s  = 1'b1;
                end else if (is_sw_s) begin
                    src_ram_d = 1'b0;
                    io_data_d = {{(DATA_W-8){1'b0}}, sw_sync_q};
                end else if (is_led_s) begin
                    src_ram_d = 1'b0;
                    io_data_d = {{(DATA_W-8){1'b0}}, led_q};
                end else begin
                    src_ram_d = 1'b0;
                    io_data_d = {DATA_W{1'b0}};
                    illegal_s = 1'b1;
                end
            end
            ST_WR: begin
                // A write in a reset cycle must not reach the array.
                if (is_ram_s) begin
                    ram_we_s = reset;
                end else if (is_led_s) begin
                    led_d = bus.write_data[7:0];
                end else begin
                    illegal_s = 1'b1;
                end
            end
            default: begin
                illegal_s = (bus.mem_cmd == MILLEGAL);
            end
        endcase

        if (illegal_s && !fault_q) begin
            fault_d      = 1'b1;
            fault_addr_d = bus.mem_addr;
        end else begin
            fault_d      = fault_q;
            fault_addr_d = fault_addr_q;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            src_ram_q    <= 1'b0;
            io_data_q    <= {DATA_W{1'b0}};
            led_q        <= 8'h00;
            fault_q      <= 1'b0;
            fault_addr_q <= {ADDR_W{1'b0}};
            sw_meta_q    <= 8'h00;
            sw_sync_q    <= 8'h00;
        end else begin
            state_q      <= state_d;
            src_ram_q    <= src_ram_d;
            io_data_q    <= io_data_d;
            led_q        <= led_d;
            fault_q      <= fault_d;
            fault_addr_q <= fault_addr_d;
            sw_meta_q    <= sw_meta_d;
            sw_sync_q    <= sw_sync_d;
        end
    end

    ram_sync_1p #(
        .DATA_W (DATA_W),
        .RAM_AW (RAM_AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we_s),
        .re    (ram_re_s),
        .addr  (bus.mem_addr[RAM_AW-1:0]),
        .wdata (bus.write_data),
        .rdata (ram_rdata_s)
    );

    // Both sources are registers; the select only picks which one was loaded last.
    assign bus.read_data  = src_ram_q ? ram_rdata_s : io_data_q;
    assign bus.fault      = fault_q;
    assign bus.fault_addr = fault_addr_q;
    assign bus.acc_state  = state_q;
    assign led_out        = led_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed vector table from the test plan, then
// randomized traffic checked against a behavioural memory model.
module tb_mem_responder;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] sw_in;
    logic [7:0] led_out;

    mem_responder_if #(.DATA_W(16), .ADDR_W(9)) bus ();

    mem_responder dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .sw_in   (sw_in),
        .led_out (led_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic [15:0] ram_m [256];
    bit          ram_ok [256];
    logic [15:0] m_rd;
    bit          m_rd_known;
    logic [7:0]  m_led;
    bit          m_fault;
    logic [8:0]  m_faddr;
    logic [7:0]  m_s1, m_s2;

    typedef struct {
        bit          rst;
        logic [1:0]  cmd;
        logic [8:0]  addr;
        logic [15:0] wd;
        logic [7:0]  sw;
        logic [15:0] rd;
        logic [7:0]  led;
        bit          f;
        logic [8:0]  fa;
    } vec_t;

    vec_t tbl [29];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // 0 = RAM, 1 = switches, 2 = LEDs, 3 = unmapped
    function automatic int addr_kind(input logic [8:0] a);
        if (a < 9'h100)  return 0;
        if (a == 9'h140) return 1;
        if (a == 9'h100) return 2;
        return 3;
    endfunction

    task automatic model_step(input bit rst, input logic [1:0] cmd, input logic [8:0] addr,
                              input logic [15:0] wd, input logic [7:0] sw);
        bit bad;
        int k;
        bad = 1'b0;
        k = addr_kind(addr);
        if (!rst) begin
            m_rd = 16'h0000; m_rd_known = 1'b1; m_led = 8'h00;
            m_fault = 1'b0; m_faddr = 9'h000; m_s1 = 8'h00; m_s2 = 8'h00;
        end else begin
            if (cmd == 2'b00) begin
                if (k == 0) begin
                    m_rd = ram_m[addr[7:0]]; m_rd_known = ram_ok[addr[7:0]];
                end else if (k == 1) begin
                    m_rd = {8'h00, m_s2}; m_rd_known = 1'b1;
                end else if (k == 2) begin
                    m_rd = {8'h00, m_led}; m_rd_known = 1'b1;
                end else begin
                    m_rd = 16'h0000; m_rd_known = 1'b1; bad = 1'b1;
                end
            end else if (cmd == 2'b10) begin
                if (k == 0) begin
                    ram_m[addr[7:0]] = wd; ram_ok[addr[7:0]] = 1'b1;
                end else if (k == 2) begin
                    m_led = wd[7:0];
                end else begin
                    bad = 1'b1;
                end
            end else if (cmd == 2'b11) begin
                bad = 1'b1;
            end
            if (bad && !m_fault) begin
                m_fault = 1'b1; m_faddr = addr;
            end
            m_s2 = m_s1;
            m_s1 = sw;
        end
    endtask

    task automatic cycle(input bit rst, input logic [1:0] cmd, input logic [8:0] addr,
                         input logic [15:0] wd, input logic [7:0] sw);
        reset          = rst;
        bus.mem_cmd    = cmd;
        bus.mem_addr   = addr;
        bus.write_data = wd;
        sw_in          = sw;
        @(posedge clk);
        model_step(rst, cmd, addr, wd, sw);
        #1;
    endtask

    task automatic check_model(input string tag);
        if (m_rd_known) chk({tag, "_rd"}, {16'h0, bus.read_data}, {16'h0, m_rd});
        chk({tag, "_led"},   {24'h0, led_out}, {24'h0, m_led});
        chk({tag, "_fault"}, {31'h0, bus.fault}, {31'h0, m_fault});
        chk({tag, "_faddr"}, {23'h0, bus.fault_addr}, {23'h0, m_faddr});
    endtask

    task automatic row(input int i, input bit rst, input logic [1:0] cmd, input logic [8:0] addr,
                       input logic [15:0] wd, input logic [7:0] sw, input logic [15:0] rd,
                       input logic [7:0] led, input bit f, input logic [8:0] fa);
        tbl[i].rst = rst; tbl[i].cmd = cmd; tbl[i].addr = addr; tbl[i].wd = wd; tbl[i].sw = sw;
        tbl[i].rd = rd; tbl[i].led = led; tbl[i].f = f; tbl[i].fa = fa;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram_m[i] = 16'h0000;
            ram_ok[i] = 1'b0;
        end
        m_rd = 16'h0000; m_rd_known = 1'b0; m_led = 8'h00; m_fault = 1'b0;
        m_faddr = 9'h000; m_s1 = 8'h00; m_s2 = 8'h00;

        //      rst cmd    addr    wd        sw     | rd        led    f  fa
        row( 0, 0, 2'b01, 9'h000, 16'h0000, 8'h00, 16'h0000, 8'h00, 0, 9'h000);
        row( 1, 1, 2'b10, 9'h005, 16'h0505, 8'h00, 16'h0000, 8'h00, 0, 9'h000);
        row( 2, 0, 2'b01, 9'h000, 16'h0000, 8'h00, 16'h0000, 8'h00, 0, 9'h000);
        row( 3, 0, 2'b01, 9'h000, 16'h0000, 8'h00, 16'h0000, 8'h00, 0, 9'h000);
        row( 4, 1, 2'b01, 9'h000, 16'h0000, 8'h00, 16'h0000, 8'h00, 0, 9'h000);
        row( 5, 1, 2'b00, 9'h005, 16'h0000, 8'h00, 16'h0505, 8'h00, 0, 9'h000);
        row( 6, 1, 2'b10, 9'h00A, 16'hBEEF, 8'h00, 16'h0505, 8'h00, 0, 9'h000);
        row( 7, 1, 2'b00, 9'h00A, 16'h0000, 8'h00, 16'hBEEF, 8'h00, 0, 9'h000);
        row( 8, 1, 2'b01, 9'h00A, 16'h0000, 8'h00, 16'hBEEF, 8'h00, 0, 9'h000);
        row( 9, 1, 2'b01, 9'h005, 16'h0000, 8'h00, 16'hBEEF, 8'h00, 0, 9'h000);
        row(10, 1, 2'b01, 9'h140, 16'h0000, 8'h00, 16'hBEEF, 8'h00, 0, 9'h000);
        row(11, 1, 2'b01, 9'h000, 16'h0000, 8'h5A, 16'hBEEF, 8'h00, 0, 9'h000);
        row(12, 1, 2'b01, 9'h000, 16'h0000, 8'h5A, 16'hBEEF, 8'h00, 0, 9'h000);
        row(13, 1, 2'b00, 9'h140, 16'h0000, 8'h5A, 16'h005A, 8'h00, 0, 9'h000);
        row(14, 1, 2'b10, 9'h100, 16'h12C3, 8'h5A, 16'h005A, 8'hC3, 0, 9'h000);
        row(15, 1, 2'b00, 9'h100, 16'h0000, 8'h5A, 16'h00C3, 8'hC3, 0, 9'h000);
        row(16, 1, 2'b10, 9'h020, 16'h2020, 8'h5A, 16'h00C3, 8'hC3, 0, 9'h000);
        row(17, 1, 2'b10, 9'h030, 16'h3030, 8'h5A, 16'h00C3, 8'hC3, 0, 9'h000);
        row(18, 1, 2'b00, 9'h1FF, 16'h0000, 8'h5A, 16'h0000, 8'hC3, 1, 9'h1FF);
        row(19, 1, 2'b10, 9'h140, 16'hABCD, 8'h5A, 16'h0000, 8'hC3, 1, 9'h1FF);
        row(20, 0, 2'b01, 9'h000, 16'h0000, 8'h5A, 16'h0000, 8'h00, 0, 9'h000);
        row(21, 1, 2'b00, 9'h00A, 16'h0000, 8'h5A, 16'hBEEF, 8'h00, 0, 9'h000);
        row(22, 1, 2'b00, 9'h005, 16'h0000, 8'h5A, 16'h0505, 8'h00, 0, 9'h000);
        row(23, 1, 2'b11, 9'h020, 16'h7777, 8'h5A, 16'h0505, 8'h00, 1, 9'h020);
        row(24, 1, 2'b00, 9'h020, 16'h0000, 8'h5A, 16'h2020, 8'h00, 1, 9'h020);
        row(25, 0, 2'b10, 9'h030, 16'h1111, 8'h5A, 16'h0000, 8'h00, 0, 9'h000);
        row(26, 1, 2'b00, 9'h030, 16'h0000, 8'h5A, 16'h3030, 8'h00, 0, 9'h000);
        row(27, 1, 2'b10, 9'h100, 16'hFF81, 8'h5A, 16'h3030, 8'h81, 0, 9'h000);
        row(28, 1, 2'b10, 9'h1FE, 16'h0000, 8'h5A, 16'h3030, 8'h81, 1, 9'h1FE);

        for (int i = 0; i < 29; i++) begin
            cycle(tbl[i].rst, tbl[i].cmd, tbl[i].addr, tbl[i].wd, tbl[i].sw);
            chk($sformatf("vec%0d_rd", i),    {16'h0, bus.read_data},  {16'h0, tbl[i].rd});
            chk($sformatf("vec%0d_led", i),   {24'h0, led_out},        {24'h0, tbl[i].led});
            chk($sformatf("vec%0d_fault", i), {31'h0, bus.fault},      {31'h0, tbl[i].f});
            chk($sformatf("vec%0d_faddr", i), {23'h0, bus.fault_addr}, {23'h0, tbl[i].fa});
        end

        // Randomized phase: fresh reset, seed RAM 0..15, then mixed traffic.
        cycle(1'b0, 2'b01, 9'h000, 16'h0000, 8'h00);
        check_model("rnd_reset");
        for (int a = 0; a < 16; a++) begin
            cycle(1'b1, 2'b10, 9'(a), 16'($urandom), 8'($urandom));
            check_model("rnd_fill");
        end
        for (int n = 0; n < 600; n++) begin
            logic [1:0]  cmd;
            logic [8:0]  addr;
            int          sel;
            bit          rst;
            cmd = 2'($urandom_range(0, 3));
            sel = int'($urandom_range(0, 9));
            if (sel < 6)       addr = 9'($urandom_range(0, 15));
            else if (sel == 6) addr = 9'h140;
            else if (sel == 7) addr = 9'h100;
            else               addr = {1'b1, 8'($urandom)};
            rst = ($urandom_range(0, 49) != 0);
            cycle(rst, cmd, addr, 16'($urandom), 8'($urandom));
            check_model("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
